// File: rtl/mem_responder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_responder_pkg : request-type / R-W / FSM encodings for mem_responder |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package mem_responder_pkg;

  localparam logic [1:0] MEM_WORD = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_BYTE = 2'b10;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Encoding 2'b11 behaves exactly like a word access.
  function automatic logic [1:0] norm_type(input logic [1:0] t);
    return (t == 2'b11) ? MEM_WORD : t;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] t);
    case (t)
      MEM_HALF: return 4'b0011;
      MEM_BYTE: return 4'b0001;
      default:  return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] read_mask(input logic [1:0] t, input logic [31:0] d);
    case (t)
      MEM_HALF: return {16'h0000, d[15:0]};
      MEM_BYTE: return {24'h000000, d[7:0]};
      default:  return d;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_byte_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_byte_array : DEPTH_BYTES x 8 RAM, 4 byte lanes starting at addr_i,   |
// |                  lane addresses wrap modulo DEPTH_BYTES                   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_byte_array #(
  parameter int unsigned DEPTH_BYTES = 256
) (
  input  logic                           clk_i,
  input  logic [3:0]                     we_i,
  input  logic [$clog2(DEPTH_BYTES)-1:0] addr_i,
  input  logic [31:0]                    wdata_i,
  output logic [31:0]                    rdata_o
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);

  logic [7:0]    mem_q [DEPTH_BYTES];
  logic [AW-1:0] lane_addr [4];

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign lane_addr[g]       = addr_i + AW'(g);
    assign rdata_o[8*g +: 8]  = mem_q[lane_addr[g]];
  end

  // Contents intentionally survive reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) begin
        mem_q[lane_addr[i]] <= wdata_i[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_responder : MOV/MOC memory responder, fixed latency, LE byte RAM.    |
// | Optional ALIGN_CHECK_EN: misaligned access flags FAULT instead of align. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        MOV,
  input  logic        RW,
  input  logic [1:0]  TYPE,
  input  logic [31:0] ADDR,
  input  logic [31:0] DATA_IN,
  output logic [31:0] DATA_OUT,
  output logic        MOC,
  output logic        FAULT
);

  localparam int unsigned AW       = $clog2(DEPTH_BYTES);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic          rw_q;
  logic [1:0]    type_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          misal_q;
  logic [31:0]   dout_q;
  logic          moc_q;
  logic          fault_q;

  logic [1:0]    type_d;
  logic [AW-1:0] addr_d;
  logic          misal_d;
  logic          commit;
  logic [3:0]    ram_we;
  logic [31:0]   ram_rdata;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^ADDR[31:AW];

  always_comb begin
    type_d  = norm_type(TYPE);
    addr_d  = ADDR[AW-1:0];
    misal_d = 1'b0;
`ifdef ALIGN_CHECK_EN
    misal_d = ((type_d == MEM_WORD) && (ADDR[1:0] != 2'b00)) ||
              ((type_d == MEM_HALF) && ADDR[0]);
`else
    if (type_d == MEM_WORD) begin
      addr_d[1:0] = 2'b00;
    end else if (type_d == MEM_HALF) begin
      addr_d[0] = 1'b0;
    end
`endif
  end

  assign commit = (state_q == ST_BUSY) && (cnt_q == 4'd0);
  assign ram_we = (commit && (rw_q == RW_WRITE) && !misal_q) ? byte_en(type_q) : 4'b0000;

  mem_byte_array #(
    .DEPTH_BYTES(DEPTH_BYTES)
  ) u_ram (
    .clk_i  (CLK),
    .we_i   (ram_we),
    .addr_i (addr_q),
    .wdata_i(wdata_q),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= RW_READ;
      type_q  <= MEM_WORD;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      misal_q <= 1'b0;
      dout_q  <= 32'h0;
      moc_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (MOV) begin
            rw_q    <= RW;
            type_q  <= type_d;
            addr_q  <= addr_d;
            wdata_q <= DATA_IN;
            misal_q <= misal_d;
            cnt_q   <= CNT_INIT;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt_q == 4'd0) begin
            moc_q   <= 1'b1;
            fault_q <= misal_q;
            if ((rw_q == RW_READ) && !misal_q) begin
              dout_q <= read_mask(type_q, ram_rdata);
            end
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_DONE: begin
          // A fresh request is only accepted after MOV has been seen low.
          if (!MOV) begin
            moc_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign DATA_OUT = dout_q;
  assign MOC      = moc_q;
  assign FAULT    = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_responder : scoreboard bench for mem_responder (LATENCY=2)        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 2;
`ifdef ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        MOV = 1'b0;
  logic        RW = 1'b0;
  logic [1:0]  TYPE = 2'b00;
  logic [31:0] ADDR = 32'h0;
  logic [31:0] DATA_IN = 32'h0;
  logic [31:0] DATA_OUT;
  logic        MOC;
  logic        FAULT;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] sb_q [$];
  logic [31:0] exp_v;

  logic [31:0] r_dout;
  logic        r_flt;
  int          r_cyc;
  bit          r_held;
  logic        r_drop;

  mem_responder #(
    .DEPTH_BYTES(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .MOV     (MOV),
    .RW      (RW),
    .TYPE    (TYPE),
    .ADDR    (ADDR),
    .DATA_IN (DATA_IN),
    .DATA_OUT(DATA_OUT),
    .MOC     (MOC),
    .FAULT   (FAULT)
  );

  always #5 CLK = ~CLK;

  // Drive one request; optionally corrupt inputs while busy and hold MOV after MOC.
  task automatic access(input logic rw, input logic [1:0] ty, input logic [31:0] a,
                        input logic [31:0] d, input bit scr, input int hold);
    @(negedge CLK);
    MOV = 1'b1; RW = rw; TYPE = ty; ADDR = a; DATA_IN = d;
    r_cyc  = 0;
    r_held = 1'b1;
    do begin
      @(negedge CLK);
      r_cyc++;
      if (scr && r_cyc == 1) begin
        ADDR = ~a; RW = ~rw; DATA_IN = ~d; TYPE = 2'b10;
      end
    end while (MOC !== 1'b1 && r_cyc < 20);
    r_dout = DATA_OUT;
    r_flt  = FAULT;
    repeat (hold) begin
      @(negedge CLK);
      if (MOC !== 1'b1) r_held = 1'b0;
    end
    MOV = 1'b0;
    @(negedge CLK);
    r_drop = MOC;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++; if (MOC !== 1'b0) begin n_err++; $display("FAIL reset_moc got=%b exp=0", MOC); end
    n_cmp++; if (FAULT !== 1'b0) begin n_err++; $display("FAIL reset_fault got=%b exp=0", FAULT); end
    n_cmp++; if (DATA_OUT !== 32'h0) begin n_err++; $display("FAIL reset_dout got=%h exp=00000000", DATA_OUT); end
    RESET_N = 1'b1;
  endtask

  task automatic test_word_rw();
    access(1'b0, 2'b00, 32'h10, 32'hDEADBEEF, 1'b0, 0);
    n_cmp++; if (r_cyc != LAT + 1) begin n_err++; $display("FAIL wr_latency got=%0d exp=%0d", r_cyc, LAT + 1); end
    n_cmp++; if (r_dout !== 32'h0) begin n_err++; $display("FAIL wr_dout_unchanged got=%h exp=00000000", r_dout); end
    sb_q.push_back(32'hDEADBEEF);
    access(1'b1, 2'b00, 32'h10, 32'h0, 1'b0, 0);
    exp_v = sb_q.pop_front();
    n_cmp++; if (r_dout !== exp_v) begin n_err++; $display("FAIL rd_word got=%h exp=%h", r_dout, exp_v); end
    n_cmp++; if (r_cyc != LAT + 1) begin n_err++; $display("FAIL rd_latency got=%0d exp=%0d", r_cyc, LAT + 1); end
    n_cmp++; if (r_drop !== 1'b0) begin n_err++; $display("FAIL rd_moc_drop got=%b exp=0", r_drop); end
  endtask

  task automatic test_subword_read();
    logic [1:0]  ty [3]  = '{2'b10, 2'b01, 2'b11};
    logic [31:0] ad [3]  = '{32'h11, 32'h12, 32'h10};
    logic [31:0] ex [3]  = '{32'h000000BE, 32'h0000DEAD, 32'hDEADBEEF};
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(ex[i]);
      access(1'b1, ty[i], ad[i], 32'h0, 1'b0, 0);
      exp_v = sb_q.pop_front();
      n_cmp++; if (r_dout !== exp_v) begin n_err++; $display("FAIL rd_sub[%0d] got=%h exp=%h", i, r_dout, exp_v); end
    end
  endtask

  task automatic test_partial_write();
    access(1'b0, 2'b10, 32'h13, 32'hAAAAAA55, 1'b0, 0);
    sb_q.push_back(32'h55ADBEEF);
    access(1'b1, 2'b00, 32'h10, 32'h0, 1'b0, 0);
    exp_v = sb_q.pop_front();
    n_cmp++; if (r_dout !== exp_v) begin n_err++; $display("FAIL byte_write got=%h exp=%h", r_dout, exp_v); end
    // 0x110 wraps onto 0x10 in a 256-byte RAM.
    access(1'b0, 2'b01, 32'h110, 32'hFFFF1234, 1'b0, 0);
    n_cmp++; if (r_dout !== 32'h55ADBEEF) begin n_err++; $display("FAIL wr_holds_dout got=%h exp=55adbeef", r_dout); end
    sb_q.push_back(32'h55AD1234);
    access(1'b1, 2'b00, 32'h10, 32'h0, 1'b0, 0);
    exp_v = sb_q.pop_front();
    n_cmp++; if (r_dout !== exp_v) begin n_err++; $display("FAIL half_write_wrap got=%h exp=%h", r_dout, exp_v); end
  endtask

  task automatic test_handshake();
    access(1'b0, 2'b00, 32'h20, 32'h11223344, 1'b0, 0);
    sb_q.push_back(32'h55AD1234);
    access(1'b1, 2'b00, 32'h10, 32'h0, 1'b1, 5);
    exp_v = sb_q.pop_front();
    n_cmp++; if (r_dout !== exp_v) begin n_err++; $display("FAIL busy_ignore got=%h exp=%h", r_dout, exp_v); end
    n_cmp++; if (r_cyc != LAT + 1) begin n_err++; $display("FAIL busy_latency got=%0d exp=%0d", r_cyc, LAT + 1); end
    n_cmp++; if (r_held !== 1'b1) begin n_err++; $display("FAIL moc_hold got=%b exp=1", r_held); end
    n_cmp++; if (r_drop !== 1'b0) begin n_err++; $display("FAIL moc_release got=%b exp=0", r_drop); end
    sb_q.push_back(32'h11223344);
    access(1'b1, 2'b00, 32'h20, 32'h0, 1'b0, 0);
    exp_v = sb_q.pop_front();
    n_cmp++; if (r_dout !== exp_v) begin n_err++; $display("FAIL busy_no_write got=%h exp=%h", r_dout, exp_v); end
  endtask

  task automatic test_align();
    access(1'b0, 2'b00, 32'h21, 32'hCAFEF00D, 1'b0, 0);
    n_cmp++; if (r_flt !== ALIGN) begin n_err++; $display("FAIL mis_wr_fault got=%b exp=%b", r_flt, ALIGN); end
    sb_q.push_back(ALIGN ? 32'h11223344 : 32'hCAFEF00D);
    access(1'b1, 2'b00, 32'h20, 32'h0, 1'b0, 0);
    exp_v = sb_q.pop_front();
    n_cmp++; if (r_dout !== exp_v) begin n_err++; $display("FAIL mis_wr_ram got=%h exp=%h", r_dout, exp_v); end
    n_cmp++; if (r_flt !== 1'b0) begin n_err++; $display("FAIL fault_clear got=%b exp=0", r_flt); end
    sb_q.push_back(ALIGN ? 32'h11223344 : 32'h0000CAFE);
    access(1'b1, 2'b01, 32'h23, 32'h0, 1'b0, 0);
    exp_v = sb_q.pop_front();
    n_cmp++; if (r_dout !== exp_v) begin n_err++; $display("FAIL mis_rd_half got=%h exp=%h", r_dout, exp_v); end
    n_cmp++; if (r_flt !== ALIGN) begin n_err++; $display("FAIL mis_rd_fault got=%b exp=%b", r_flt, ALIGN); end
    sb_q.push_back(ALIGN ? 32'h00000044 : 32'h0000000D);
    access(1'b1, 2'b10, 32'h20, 32'h0, 1'b0, 0);
    exp_v = sb_q.pop_front();
    n_cmp++; if (r_dout !== exp_v) begin n_err++; $display("FAIL byte_any_addr got=%h exp=%h", r_dout, exp_v); end
  endtask

  task automatic test_reset_abort();
    int w;
    // Reset while MOC is held high in DONE.
    @(negedge CLK);
    MOV = 1'b1; RW = 1'b1; TYPE = 2'b00; ADDR = 32'h10;
    w = 0;
    while (MOC !== 1'b1 && w < 20) begin @(negedge CLK); w++; end
    n_cmp++; if (MOC !== 1'b1) begin n_err++; $display("FAIL done_reached got=%b exp=1", MOC); end
    RESET_N = 1'b0;
    #1;
    n_cmp++; if (MOC !== 1'b0) begin n_err++; $display("FAIL async_rst_moc got=%b exp=0", MOC); end
    n_cmp++; if (DATA_OUT !== 32'h0) begin n_err++; $display("FAIL async_rst_dout got=%h exp=00000000", DATA_OUT); end
    MOV = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    // Reset in BUSY of a write: the write must be dropped.
    @(negedge CLK);
    MOV = 1'b1; RW = 1'b0; TYPE = 2'b00; ADDR = 32'h10; DATA_IN = 32'h99999999;
    @(negedge CLK);
    RESET_N = 1'b0;
    MOV = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    sb_q.push_back(32'h55AD1234);
    access(1'b1, 2'b00, 32'h10, 32'h0, 1'b0, 0);
    exp_v = sb_q.pop_front();
    n_cmp++; if (r_dout !== exp_v) begin n_err++; $display("FAIL abort_write got=%h exp=%h", r_dout, exp_v); end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_subword_read();
    test_partial_write();
    test_handshake();
    test_align();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
